// File: rtl/sonar_uc.sv
`default_nettype none
// ============================================================================
// Module      : sonar_uc
// Description : Control unit (Moore FSM) for the sonar sweep. Each sweep step
//               triggers a distance measurement, sends the 8-character frame
//               "ccc,ddd#", waits the inter-measurement interval and then
//               advances the servo position. A watchdog bounds the wait for
//               the echo so that a missing echo cannot stall the sweep.
// Ports       : clock                  - system clock, rising edge
//               reset                  - asynchronous reset, active low
//               ligar                  - run sweep (sampled in INICIAL/AVANCA)
//               fim_distancia          - measurement ready pulse
//               fim_transmissao        - current character sent
//               fim_contador_serial    - character index is the last one
//               fim_contador_intervalo - interval counter terminal count
//               medir                  - start measurement pulse
//               transmitir             - start character transmission pulse
//               conta_serial           - advance character index
//               conta_intervalo        - enable interval counter
//               conta_updown           - advance servo position
//               reset_updown           - clear servo position counter
//               pronto                 - one pulse per completed sweep step
//               erro_medida            - sticky echo-timeout flag
//               db_estado              - current state code
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_uc #(
    parameter int TIMEOUT_CICLOS = 2_500_000,
    parameter int N_TIMEOUT      = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_distancia,
    input  logic       fim_transmissao,
    input  logic       fim_contador_serial,
    input  logic       fim_contador_intervalo,
    output logic       medir,
    output logic       transmitir,
    output logic       conta_serial,
    output logic       conta_intervalo,
    output logic       conta_updown,
    output logic       reset_updown,
    output logic       pronto,
    output logic       erro_medida,
    output logic [3:0] db_estado
);

    // ------------------------------------------------------------------------
    // State encoding (codes are visible on db_estado)
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_INICIAL        = 4'd0;
    localparam logic [3:0] c_PREPARA        = 4'd1;
    localparam logic [3:0] c_MEDE           = 4'd2;
    localparam logic [3:0] c_AGUARDA_MEDIDA = 4'd3;
    localparam logic [3:0] c_TRANSMITE      = 4'd4;
    localparam logic [3:0] c_AGUARDA_TX     = 4'd5;
    localparam logic [3:0] c_PROXIMO_CHAR   = 4'd6;
    localparam logic [3:0] c_ESPERA         = 4'd7;
    localparam logic [3:0] c_AVANCA         = 4'd8;
    localparam logic [3:0] c_ERRO           = 4'd9;

    // Last watchdog value that still accepts an echo; the counter parks here.
    localparam logic [N_TIMEOUT-1:0] c_WD_LIMITE = N_TIMEOUT'(TIMEOUT_CICLOS - 1);
    localparam logic [N_TIMEOUT-1:0] c_WD_UM     = N_TIMEOUT'(1);

    logic [3:0]           r_estado;
    logic [N_TIMEOUT-1:0] r_watchdog;
    logic                 r_erro;
    logic                 w_timeout;

    assign w_timeout = (r_watchdog == c_WD_LIMITE);

    // ------------------------------------------------------------------------
    // State register, watchdog and sticky error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= c_INICIAL;
            r_watchdog <= '0;
            r_erro     <= 1'b0;
        end else begin
            case (r_estado)
                c_INICIAL: begin
                    if (ligar) r_estado <= c_PREPARA;
                end

                c_PREPARA: begin
                    r_erro   <= 1'b0;
                    r_estado <= c_MEDE;
                end

                c_MEDE: begin
                    r_watchdog <= '0;
                    r_estado   <= c_AGUARDA_MEDIDA;
                end

                c_AGUARDA_MEDIDA: begin
                    // Saturating count: the limit is held rather than wrapped.
                    if (!w_timeout) r_watchdog <= r_watchdog + c_WD_UM;
                    // A late echo arriving together with the timeout still wins.
                    if (fim_distancia)  r_estado <= c_TRANSMITE;
                    else if (w_timeout) r_estado <= c_ERRO;
                end

                c_TRANSMITE: begin
                    r_estado <= c_AGUARDA_TX;
                end

                c_AGUARDA_TX: begin
                    if (fim_transmissao) r_estado <= c_PROXIMO_CHAR;
                end

                c_PROXIMO_CHAR: begin
                    if (fim_contador_serial) r_estado <= c_ESPERA;
                    else                     r_estado <= c_TRANSMITE;
                end

                c_ESPERA: begin
                    if (fim_contador_intervalo) r_estado <= c_AVANCA;
                end

                c_AVANCA: begin
                    if (ligar) r_estado <= c_MEDE;
                    else       r_estado <= c_INICIAL;
                end

                c_ERRO: begin
                    // No frame for a failed measurement; the sweep continues.
                    r_erro   <= 1'b1;
                    r_estado <= c_ESPERA;
                end

                default: begin
                    r_estado <= c_INICIAL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode: depends on the state register only
    // ------------------------------------------------------------------------
    assign reset_updown    = (r_estado == c_PREPARA);
    assign medir           = (r_estado == c_MEDE);
    assign transmitir      = (r_estado == c_TRANSMITE);
    assign conta_serial    = (r_estado == c_PROXIMO_CHAR);
    assign conta_intervalo = (r_estado == c_ESPERA);
    assign conta_updown    = (r_estado == c_AVANCA);
    assign pronto          = (r_estado == c_AVANCA);
    assign erro_medida     = r_erro;
    assign db_estado       = r_estado;

endmodule
`default_nettype wire
